serial_add_sub: RTL and testbench

- Parametrised, multi-cycle add/subtract unit for the processor datapath.
- Generalises the 4-bit ripple adder to WIDTH bits.
- Processes DIGIT bits per clock through one ripple slice, so area is traded for latency.
- Adds subtract and carry-chained modes, NZCV flags and a valid/ready handshake on both sides.
- Sits between the register file read ports and the writeback mux.

---
 rtl/serial_add_sub_pkg.sv | 34 +++
 rtl/serial_add_sub_slice.sv | 32 +++
 rtl/serial_add_sub.sv | 158 +++++++++++++++
 tb/tb_serial_add_sub.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared types and helpers for the serial add/subtract unit
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBC = 2'd3
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of slice passes needed to cover a full operand.
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never zero even when a single pass suffices.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_slice.sv
// rtl/serial_add_sub_slice.sv - combinational DIGIT-bit ripple adder slice
module add_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  // Ripple the carry through the digit, bit by bit.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < DIGIT; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[DIGIT];
  // Carry into the top bit of the digit; on the last digit this is the carry into the MSB.
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - multi-cycle digit-serial add/subtract unit with NZCV flags
module serial_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_stored_c;
  flags_t           r_flags;

  op_e              w_op;
  logic [WIDTH-1:0] w_bp;
  logic             w_cin;
  logic             w_accept;
  logic             w_last;
  int               w_sh;
  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_res_next;
  flags_t           w_flags;

  assign w_op     = op_e'(op);
  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  // Operand conditioning: subtraction is A + ~B + carry-in.
  always_comb begin
    w_bp  = num2;
    w_cin = 1'b0;
    case (w_op)
      OP_ADD: begin w_bp = num2;  w_cin = 1'b0;       end
      OP_SUB: begin w_bp = ~num2; w_cin = 1'b1;       end
      OP_ADC: begin w_bp = num2;  w_cin = r_stored_c; end
      OP_SBC: begin w_bp = ~num2; w_cin = r_stored_c; end
      default: begin w_bp = num2; w_cin = 1'b0;       end
    endcase
  end

  // Select the current digit and merge the slice output back into the result word.
  always_comb begin
    w_sh       = int'(r_cnt) * DIGIT;
    w_da       = DIGIT'(r_a >> w_sh);
    w_db       = DIGIT'(r_b >> w_sh);
    w_res_next = (r_res & ~(DMASK << w_sh)) | (WIDTH'(w_sum) << w_sh);
    w_flags.n  = w_res_next[WIDTH-1];
    w_flags.z  = ~|w_res_next;
    w_flags.c  = w_cout;
    w_flags.v  = w_cmsb ^ w_cout;
  end

  add_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .i_a   (w_da),
    .i_b   (w_db),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout),
    .o_cmsb(w_cmsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, digit-serial accumulation, flag latch and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_stored_c <= 1'b0;
      r_flags    <= '0;
    end else if (w_accept) begin
      r_a     <= num1;
      r_b     <= w_bp;
      r_carry <= w_cin;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_flags    <= w_flags;
        r_stored_c <= w_cout;
      end
    end
  end

  assign result = r_res;
  assign flag_n = r_flags.n;
  assign flag_z = r_flags.z;
  assign flag_c = r_flags.c;
  assign flag_v = r_flags.v;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard bench for serial_add_sub at 4x1 and 8x4 geometries
module tb_serial_add_sub;

  localparam int PER = 10;

  typedef struct {
    int  res;
    bit  n;
    bit  z;
    bit  c;
    bit  v;
    time t_acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv[2];
  logic       ir[2];
  logic       ov[2];
  logic       ordy[2];
  logic [1:0] opc[2];
  logic [7:0] a[2];
  logic [7:0] b[2];
  logic [3:0] r4;
  logic [7:0] r8;
  logic       fn[2];
  logic       fz[2];
  logic       fc[2];
  logic       fv[2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   have_cur[2];
  bit   ref_c[2];
  bit   rand_rdy;
  int   errors = 0;
  int   checks = 0;

  always #(PER/2) clk = ~clk;

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(opc[0]),
    .num1(a[0][3:0]), .num2(b[0][3:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(r4), .flag_n(fn[0]), .flag_z(fz[0]), .flag_c(fc[0]), .flag_v(fv[0])
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(opc[1]),
    .num1(a[1]), .num2(b[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(r8), .flag_n(fn[1]), .flag_z(fz[1]), .flag_c(fc[1]), .flag_v(fv[1])
  );

  function automatic int wid(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int ndig(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int res_of(input int d);
    return (d == 0) ? int'(r4) : int'(r8);
  endfunction

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic exp_t ref_op(input int w, input int x, input int y, input int o, input bit sc);
    exp_t e;
    int mask, bp, cin, full, sa, sb, s, half;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    bp   = (o == 1 || o == 3) ? (~y) & mask : y & mask;
    cin  = (o == 0) ? 0 : (o == 1) ? 1 : int'(sc);
    full = (x & mask) + bp + cin;
    e.res = full & mask;
    e.c   = ((full >> w) & 1) != 0;
    e.n   = ((e.res >> (w - 1)) & 1) != 0;
    e.z   = (e.res == 0);
    sa    = ((x & mask) >= half) ? (x & mask) - (1 << w) : (x & mask);
    sb    = (bp >= half) ? bp - (1 << w) : bp;
    s     = sa + sb + cin;
    e.v   = (s > half - 1) || (s < -half);
    e.t_acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: compares every presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] === 1'b1) begin
          if (!have_cur[d]) begin
            if (qsize(d) == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_out_valid dut%0d: got out_valid=1 expected no pending op", d);
            end else begin
              cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
              have_cur[d] = 1'b1;
              check($sformatf("latency_dut%0d", d), int'($time - cur[d].t_acc),
                    ndig(d) * PER + PER/2);
            end
          end
          if (have_cur[d]) begin
            check($sformatf("result_dut%0d", d), res_of(d), cur[d].res);
            check($sformatf("flag_n_dut%0d", d), int'(fn[d]), int'(cur[d].n));
            check($sformatf("flag_z_dut%0d", d), int'(fz[d]), int'(cur[d].z));
            check($sformatf("flag_c_dut%0d", d), int'(fc[d]), int'(cur[d].c));
            check($sformatf("flag_v_dut%0d", d), int'(fv[d]), int'(cur[d].v));
            check($sformatf("in_ready_done_dut%0d", d), int'(ir[d]), 0);
            if (ordy[d] === 1'b1) have_cur[d] = 1'b0;
          end
        end
      end
    end
  end

  // Random consumer backpressure.
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      ordy[0] = 1'($urandom_range(0, 1));
      ordy[1] = 1'($urandom_range(0, 1));
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int d, input int o, input int x, input int y);
    int   guard;
    exp_t e;
    guard = 0;
    while (ir[d] !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (ir[d] !== 1'b1) begin
      check($sformatf("in_ready_timeout_dut%0d", d), int'(ir[d]), 1);
      return;
    end
    opc[d] = 2'(o);
    a[d]   = 8'(x);
    b[d]   = 8'(y);
    iv[d]  = 1'b1;
    @(posedge clk);
    e = ref_op(wid(d), x, y, o, ref_c[d]);
    e.t_acc = $time;
    ref_c[d] = e.c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    #1;
    iv[d] = 1'b0;
    a[d]  = 8'($urandom);
    b[d]  = 8'($urandom);
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while ((qsize(d) != 0 || have_cur[d] || ov[d] === 1'b1) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check($sformatf("drain_timeout_dut%0d", d), guard < 300 ? 1 : 0, 1);
  endtask

  task automatic check_idle(input int d);
    check($sformatf("idle_in_ready_dut%0d", d), int'(ir[d]), 1);
    check($sformatf("idle_out_valid_dut%0d", d), int'(ov[d]), 0);
    check($sformatf("idle_result_dut%0d", d), res_of(d), 0);
    check($sformatf("idle_flags_dut%0d", d), int'({fn[d], fz[d], fc[d], fv[d]}), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    have_cur[0] = 1'b0;
    have_cur[1] = 1'b0;
    ref_c[0] = 1'b0;
    ref_c[1] = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    rand_rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; opc[d] = 2'd0; a[d] = 8'd0; b[d] = 8'd0;
      have_cur[d] = 1'b0; ref_c[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(0);
    check_idle(1);

    // Arithmetic corner cases and the carry chain on the 4x1 unit.
    issue(0, 0, 7, 9);
    issue(0, 1, 5, 3);
    issue(0, 1, 3, 5);
    issue(0, 0, 7, 1);
    issue(0, 1, 8, 1);
    issue(0, 0, 15, 1);
    issue(0, 2, 0, 0);
    issue(0, 3, 5, 2);
    drain(0);

    // Backpressure in DONE plus an overlapping in_valid pulse during RUN.
    ordy[0] = 1'b0;
    issue(0, 1, 3, 5);
    opc[0] = 2'd0; a[0] = 8'd1; b[0] = 8'd1; iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    guard = 0;
    while (ov[0] !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("backpressure_wait", int'(ov[0]), 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    drain(0);

    // Abort mid-RUN after setting the stored carry; the next ADC must see carry 0.
    issue(0, 0, 15, 1);
    drain(0);
    issue(0, 0, 15, 15);
    @(posedge clk);
    #1;
    pulse_reset();
    check_idle(0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_out_valid", int'(ov[0]), 0);
    issue(0, 2, 0, 0);
    drain(0);

    // Wide geometry: two digits of four bits.
    issue(1, 0, 8'h7F, 8'h01);
    issue(1, 1, 8'h80, 8'h01);
    issue(1, 3, 8'h10, 8'h20);
    drain(1);

    // Randomized traffic on both units with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) issue(0, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
    for (int i = 0; i < 20; i++) issue(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
